// File: rtl/i2c_slave_regfile.sv
// I2C target with a byte-addressed register file: write a pointer, then write or read data bytes with auto-increment.
// Optional SCL stretching at the start of every read byte is enabled by defining I2C_SLV_STRETCH_EN.
module i2c_slave_regfile #(
    parameter logic [6:0] SLV_ADDR    = 7'h50,
    parameter int         DEPTH       = 16,
    parameter int         STRETCH_CYC = 8
) (
    input  logic                     PCLK,
    input  logic                     PRESETN,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     slv_scl_pad_o,
    output logic                     slv_scl_pad_oe,
    output logic                     slv_sda_pad_o,
    output logic                     slv_sda_pad_oe,
    output logic                     busy,
    output logic                     wr_stb,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [7:0]               wr_data
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;

    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0 || STRETCH_CYC < 1) begin : g_param_check
        $error("i2c_slave_regfile: unsupported DEPTH or STRETCH_CYC");
    end

    logic [2:0]    sclPipe_q, sdaPipe_q;
    logic          sclNow, sclPrev, sdaNow, sdaPrev;
    logic          sclRise, sclFall, startDet, stopDet;
    logic [3:0]    state_q, state_d;
    logic [3:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sdaOe_q, sdaOe_d;
    logic          busy_q, busy_d;
    logic          wrStb_q, wrStb_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [7:0]    wrData_q, wrData_d;
    logic          regWe;
    logic [7:0]    regs_q [DEPTH];
    logic [7:0]    rdByte;

    // Bit 0 is the first synchronizer stage, bit 1 the synchronized value, bit 2 its history.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sclPipe_q <= 3'b111;
            sdaPipe_q <= 3'b111;
        end else begin
            sclPipe_q <= {sclPipe_q[1:0], scl_i};
            sdaPipe_q <= {sdaPipe_q[1:0], sda_i};
        end
    end

    assign sclNow   = sclPipe_q[1];
    assign sclPrev  = sclPipe_q[2];
    assign sdaNow   = sdaPipe_q[1];
    assign sdaPrev  = sdaPipe_q[2];
    assign sclRise  = sclNow & ~sclPrev;
    assign sclFall  = ~sclNow & sclPrev;
    assign startDet = sclNow & sclPrev & sdaPrev & ~sdaNow;
    assign stopDet  = sclNow & sclPrev & ~sdaPrev & sdaNow;
    assign rdByte   = regs_q[ptr_q];

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        ptr_d    = ptr_q;
        sdaOe_d  = sdaOe_q;
        busy_d   = busy_q;
        wrStb_d  = 1'b0;
        wrPtr_d  = wrPtr_q;
        wrData_d = wrData_q;
        regWe    = 1'b0;
        if (stopDet) begin
            state_d  = S_IDLE;
            sdaOe_d  = 1'b0;
            busy_d   = 1'b0;
            bitCnt_d = 4'd0;
        end else if (startDet) begin
            state_d  = S_ADDR;
            sdaOe_d  = 1'b0;
            bitCnt_d = 4'd0;
        end else if (state_q == S_ADDR || state_q == S_PTR || state_q == S_WDATA) begin
            if (sclRise) begin
                shift_d  = {shift_q[6:0], sdaNow};
                bitCnt_d = bitCnt_q + 4'd1;
                if (bitCnt_q == 4'd7) begin
                    bitCnt_d = 4'd0;
                    if (state_q == S_ADDR) begin
                        if (shift_d[7:1] == SLV_ADDR) begin
                            state_d = S_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (state_q == S_PTR) begin
                        ptr_d   = shift_d[PW-1:0];
                        state_d = S_PTR_ACK;
                    end else begin
                        regWe    = 1'b1;
                        wrStb_d  = 1'b1;
                        wrPtr_d  = ptr_q;
                        wrData_d = shift_d;
                        state_d  = S_WDATA_ACK;
                    end
                end
            end
        end else if (state_q == S_ADDR_ACK || state_q == S_PTR_ACK || state_q == S_WDATA_ACK) begin
            // First fall drives the ACK low, the second fall ends the ACK bit.
            if (sclFall) begin
                if (bitCnt_q == 4'd0) begin
                    sdaOe_d  = 1'b1;
                    bitCnt_d = 4'd1;
                end else begin
                    sdaOe_d  = 1'b0;
                    bitCnt_d = 4'd0;
                    if (state_q == S_ADDR_ACK && shift_q[0]) begin
                        state_d = S_RDATA;
                        shift_d = rdByte;
                        sdaOe_d = ~rdByte[7];
                    end else if (state_q == S_ADDR_ACK) begin
                        state_d = S_PTR;
                    end else if (state_q == S_PTR_ACK) begin
                        state_d = S_WDATA;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = S_WDATA;
                    end
                end
            end
        end else if (state_q == S_RDATA) begin
            if (sclRise) begin
                bitCnt_d = bitCnt_q + 4'd1;
            end else if (sclFall && bitCnt_q == 4'd8) begin
                sdaOe_d  = 1'b0;
                bitCnt_d = 4'd0;
                state_d  = S_RDATA_ACK;
            end else if (sclFall && bitCnt_q != 4'd0) begin
                shift_d = {shift_q[6:0], 1'b0};
                sdaOe_d = ~shift_q[6];
            end
        end else if (state_q == S_RDATA_ACK) begin
            if (sclRise) begin
                if (!sdaNow) begin
                    ptr_d    = ptr_q + 1'b1;
                    bitCnt_d = 4'd1;
                end else begin
                    state_d = S_IGNORE;
                end
            end else if (sclFall && bitCnt_q == 4'd1) begin
                state_d  = S_RDATA;
                bitCnt_d = 4'd0;
                shift_d  = rdByte;
                sdaOe_d  = ~rdByte[7];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q  <= S_IDLE;
            bitCnt_q <= 4'd0;
            shift_q  <= 8'h00;
            ptr_q    <= '0;
            sdaOe_q  <= 1'b0;
            busy_q   <= 1'b0;
            wrStb_q  <= 1'b0;
            wrPtr_q  <= '0;
            wrData_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            ptr_q    <= ptr_d;
            sdaOe_q  <= sdaOe_d;
            busy_q   <= busy_d;
            wrStb_q  <= wrStb_d;
            wrPtr_q  <= wrPtr_d;
            wrData_q <= wrData_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (regWe) begin
            regs_q[ptr_q] <= wrData_d;
        end
    end

`ifdef I2C_SLV_STRETCH_EN
    localparam int SW = $clog2(STRETCH_CYC + 1);

    logic          loadStretch;
    logic [SW-1:0] stretchCnt_q;

    // Same fall that puts bit 7 of a read byte on SDA, so SDA is settled before SCL is released.
    assign loadStretch = sclFall && (bitCnt_q == 4'd1) &&
                         ((state_q == S_ADDR_ACK && shift_q[0]) || state_q == S_RDATA_ACK);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            stretchCnt_q <= '0;
        end else if (loadStretch) begin
            stretchCnt_q <= SW'(STRETCH_CYC);
        end else if (stretchCnt_q != '0) begin
            stretchCnt_q <= stretchCnt_q - 1'b1;
        end
    end

    assign slv_scl_pad_oe = (stretchCnt_q != '0);
`else
    assign slv_scl_pad_oe = 1'b0;
`endif

    assign slv_scl_pad_o  = 1'b0;
    assign slv_sda_pad_o  = 1'b0;
    assign slv_sda_pad_oe = sdaOe_q;
    assign busy           = busy_q;
    assign wr_stb         = wrStb_q;
    assign wr_ptr         = wrPtr_q;
    assign wr_data        = wrData_q;
endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Self-checking bench for i2c_slave_regfile: a bit-banged I2C master on a wired-AND bus plus a register-file model.
module tb_i2c_slave_regfile;
    localparam logic [6:0] SLV_ADDR    = 7'h50;
    localparam int         DEPTH       = 16;
    localparam int         STRETCH_CYC = 8;
    localparam int         PW          = $clog2(DEPTH);
    localparam int         Q           = 5;

    logic          PCLK    = 1'b0;
    logic          PRESETN = 1'b0;
    logic          mScl    = 1'b1;
    logic          mSda    = 1'b1;
    logic          sclBus, sdaBus;
    logic          sclO, sclOe, sdaO, sdaOe, busy, wrStb;
    logic [PW-1:0] wrPtr;
    logic [7:0]    wrData;

    int total = 0;
    int bad   = 0;

    logic [7:0]    modelRegs [DEPTH];
    int            modelPtr;
    logic [PW+7:0] wrQ[$];
    logic [PW+7:0] expQ[$];
    int            sclOeCycles;
    logic          sdaOeSeen;

    assign sclBus = mScl & ~sclOe;
    assign sdaBus = mSda & ~sdaOe;

    always #5 PCLK = ~PCLK;

    i2c_slave_regfile #(
        .SLV_ADDR   (SLV_ADDR),
        .DEPTH      (DEPTH),
        .STRETCH_CYC(STRETCH_CYC)
    ) dut (
        .PCLK          (PCLK),
        .PRESETN       (PRESETN),
        .scl_i         (sclBus),
        .sda_i         (sdaBus),
        .slv_scl_pad_o (sclO),
        .slv_scl_pad_oe(sclOe),
        .slv_sda_pad_o (sdaO),
        .slv_sda_pad_oe(sdaOe),
        .busy          (busy),
        .wr_stb        (wrStb),
        .wr_ptr        (wrPtr),
        .wr_data       (wrData)
    );

    always @(negedge PCLK) begin
        if (wrStb) wrQ.push_back({wrPtr, wrData});
        if (sclOe) sclOeCycles++;
        if (sdaOe) sdaOeSeen = 1'b1;
    end

    initial begin
        repeat (90000) @(posedge PCLK);
        $display("[TB] FAIL watchdog got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic waitSclHigh();
        int guard = 0;
        while (sclBus !== 1'b1 && guard < 200) begin
            @(negedge PCLK);
            guard++;
        end
        if (sclBus !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL scl_release got=%b want=1", sclBus);
        end
    endtask

    // One bit: enter with SCL low, leave a quarter period after the falling edge.
    task automatic mBit(input logic b, output logic r);
        mSda = b;
        waitCycles(Q);
        mScl = 1'b1;
        waitSclHigh();
        waitCycles(Q);
        r = sdaBus;
        waitCycles(Q);
        mScl = 1'b0;
        waitCycles(Q);
    endtask

    task automatic mStart();
        if (sclBus === 1'b0) begin
            mSda = 1'b1;
            waitCycles(Q);
            mScl = 1'b1;
            waitSclHigh();
        end
        waitCycles(Q);
        mSda = 1'b0;
        waitCycles(2 * Q);
        mScl = 1'b0;
        waitCycles(Q);
    endtask

    task automatic mStop();
        mSda = 1'b0;
        waitCycles(Q);
        mScl = 1'b1;
        waitSclHigh();
        waitCycles(2 * Q);
        mSda = 1'b1;
        waitCycles(2 * Q);
    endtask

    task automatic mWriteByte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) mBit(b[i], r);
        mBit(1'b1, r);
        ack = ~r;
    endtask

    task automatic mReadByte(input logic giveAck, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            mBit(1'b1, r);
            d[i] = r;
        end
        mBit(~giveAck, r);
    endtask

    function automatic void modelWrite(input logic [7:0] b);
        expQ.push_back({PW'(modelPtr), b});
        modelRegs[modelPtr] = b;
        modelPtr = (modelPtr + 1) % DEPTH;
    endfunction

    task automatic test_reset();
        PRESETN = 1'b0;
        mScl = 1'b1;
        mSda = 1'b1;
        for (int i = 0; i < DEPTH; i++) modelRegs[i] = 8'h00;
        modelPtr = 0;
        waitCycles(4);
        total++;
        if ({sclO, sclOe, sdaO, sdaOe, busy, wrStb} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl got=%b want=000000", {sclO, sclOe, sdaO, sdaOe, busy, wrStb});
        end
        total++;
        if ({wrPtr, wrData} !== '0) begin
            bad++;
            $display("[TB] FAIL reset_wr got=%h want=0", {wrPtr, wrData});
        end
        PRESETN = 1'b1;
        waitCycles(6);
        total++;
        if ({sdaOe, busy, wrStb} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL after_reset got=%b want=000", {sdaOe, busy, wrStb});
        end
    endtask

    task automatic test_write_basic();
        logic ack;
        logic [7:0] bytes [4] = '{8'hA0, 8'h03, 8'hA5, 8'h5A};
        wrQ.delete();
        expQ.delete();
        mStart();
        for (int i = 0; i < 4; i++) begin
            mWriteByte(bytes[i], ack);
            total++;
            if (ack !== 1'b1) begin
                bad++;
                $display("[TB] FAIL basic_ack%0d got=%b want=1", i, ack);
            end
            if (i == 0) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL basic_busy got=%b want=1", busy);
                end
            end
        end
        mStop();
        modelPtr = 3;
        modelWrite(8'hA5);
        modelWrite(8'h5A);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_busy_stop got=%b want=0", busy);
        end
        total++;
        if (wrQ.size() != expQ.size() || wrQ != expQ) begin
            bad++;
            $display("[TB] FAIL basic_wr got=%p want=%p", wrQ, expQ);
        end
    endtask

    task automatic test_wrap();
        logic ack;
        logic [7:0] bytes [4] = '{8'hA0, 8'h0F, 8'h11, 8'h22};
        wrQ.delete();
        expQ.delete();
        mStart();
        for (int i = 0; i < 4; i++) begin
            mWriteByte(bytes[i], ack);
            total++;
            if (ack !== 1'b1) begin
                bad++;
                $display("[TB] FAIL wrap_ack%0d got=%b want=1", i, ack);
            end
        end
        mStop();
        modelPtr = 15;
        modelWrite(8'h11);
        modelWrite(8'h22);
        total++;
        if (wrQ != expQ) begin
            bad++;
            $display("[TB] FAIL wrap_wr got=%p want=%p", wrQ, expQ);
        end
    endtask

    task automatic test_nack();
        logic ack;
        wrQ.delete();
        sdaOeSeen = 1'b0;
        mStart();
        mWriteByte(8'hA2, ack);
        total++;
        if (ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL nack_addr got=%b want=0", ack);
        end
        mWriteByte(8'h3C, ack);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL nack_busy got=%b want=0", busy);
        end
        mStop();
        total++;
        if (sdaOeSeen !== 1'b0 || wrQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL nack_quiet got=oe%b/wr%0d want=oe0/wr0", sdaOeSeen, wrQ.size());
        end
    endtask

    task automatic test_repeated_start_read();
        logic ack;
        logic [7:0] d0, d1;
        wrQ.delete();
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h03, ack);
        mStart();
        mWriteByte(8'hA1, ack);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rs_addr_ack got=%b want=1", ack);
        end
        mReadByte(1'b1, d0);
        mReadByte(1'b0, d1);
        total++;
        if (sdaOe !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rs_release got=%b want=0", sdaOe);
        end
        mStop();
        modelPtr = 4;
        total++;
        if (d0 !== modelRegs[3] || d1 !== modelRegs[4]) begin
            bad++;
            $display("[TB] FAIL rs_data got=%h,%h want=%h,%h", d0, d1, modelRegs[3], modelRegs[4]);
        end
        total++;
        if (wrQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL rs_no_write got=%0d want=0", wrQ.size());
        end
    endtask

    task automatic test_abort_partial();
        logic ack, r;
        logic [7:0] d;
        wrQ.delete();
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h06, ack);
        mBit(1'b1, r);
        mBit(1'b0, r);
        mBit(1'b1, r);
        mBit(1'b1, r);
        mStart();
        mWriteByte(8'hA1, ack);
        mReadByte(1'b0, d);
        mStop();
        modelPtr = 6;
        total++;
        if (d !== modelRegs[6] || wrQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL abort_partial got=%h/wr%0d want=%h/wr0", d, wrQ.size(), modelRegs[6]);
        end
    endtask

    task automatic test_random();
        logic ack;
        logic [7:0] d, b, ptrByte;
        int n, nacks;
        for (int it = 0; it < 6; it++) begin
            wrQ.delete();
            expQ.delete();
            ptrByte = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            nacks = 0;
            mStart();
            mWriteByte(8'hA0, ack);
            if (!ack) nacks++;
            mWriteByte(ptrByte, ack);
            if (!ack) nacks++;
            modelPtr = ptrByte % DEPTH;
            for (int j = 0; j < n; j++) begin
                b = 8'($urandom);
                mWriteByte(b, ack);
                if (!ack) nacks++;
                modelWrite(b);
            end
            mStop();
            total++;
            if (nacks != 0 || wrQ != expQ) begin
                bad++;
                $display("[TB] FAIL rand_write%0d got=nack%0d/%p want=nack0/%p", it, nacks, wrQ, expQ);
            end
            ptrByte = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 4);
            mStart();
            mWriteByte(8'hA0, ack);
            mWriteByte(ptrByte, ack);
            mStart();
            mWriteByte(8'hA1, ack);
            modelPtr = ptrByte % DEPTH;
            for (int j = 0; j < n; j++) begin
                mReadByte(j != n - 1, d);
                total++;
                if (d !== modelRegs[modelPtr]) begin
                    bad++;
                    $display("[TB] FAIL rand_read%0d_%0d got=%h want=%h", it, j, d, modelRegs[modelPtr]);
                end
                if (j != n - 1) modelPtr = (modelPtr + 1) % DEPTH;
            end
            mStop();
        end
    endtask

    task automatic test_stretch();
        logic ack;
        logic [7:0] d0, d1;
        int expCycles;
        modelRegs[3] = 8'hC3;
        modelRegs[4] = 8'h3C;
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h03, ack);
        mWriteByte(8'hC3, ack);
        mWriteByte(8'h3C, ack);
        mStop();
        sclOeCycles = 0;
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h03, ack);
        mStart();
        mWriteByte(8'hA1, ack);
        mReadByte(1'b1, d0);
        mReadByte(1'b0, d1);
        mStop();
        modelPtr = 4;
`ifdef I2C_SLV_STRETCH_EN
        expCycles = 2 * STRETCH_CYC;
`else
        expCycles = 0;
`endif
        total++;
        if (sclOeCycles != expCycles) begin
            bad++;
            $display("[TB] FAIL stretch_cycles got=%0d want=%0d", sclOeCycles, expCycles);
        end
        total++;
        if (d0 !== 8'hC3 || d1 !== 8'h3C) begin
            bad++;
            $display("[TB] FAIL stretch_data got=%h,%h want=c3,3c", d0, d1);
        end
    endtask

    task automatic test_reset_midread();
        logic ack, r;
        logic [7:0] d;
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h07, ack);
        mWriteByte(8'h00, ack);
        mStop();
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h07, ack);
        mStart();
        mWriteByte(8'hA1, ack);
        mBit(1'b1, r);
        mBit(1'b1, r);
        mBit(1'b1, r);
        total++;
        if (sdaOe !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midread_drive got=%b want=1", sdaOe);
        end
        @(posedge PCLK);
        #2;
        PRESETN = 1'b0;
        #1;
        total++;
        if (sdaOe !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midread_release got=oe%b/busy%b want=oe0/busy0", sdaOe, busy);
        end
        mScl = 1'b1;
        mSda = 1'b1;
        waitCycles(4);
        PRESETN = 1'b1;
        for (int i = 0; i < DEPTH; i++) modelRegs[i] = 8'h00;
        modelPtr = 0;
        waitCycles(4);
        mStart();
        mWriteByte(8'hA1, ack);
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL post_reset_ack got=%b want=1", ack);
        end
        mReadByte(1'b0, d);
        mStop();
        total++;
        if (d !== modelRegs[modelPtr]) begin
            bad++;
            $display("[TB] FAIL post_reset_ptr0 got=%h want=%h", d, modelRegs[modelPtr]);
        end
        mStart();
        mWriteByte(8'hA0, ack);
        mWriteByte(8'h03, ack);
        mStart();
        mWriteByte(8'hA1, ack);
        mReadByte(1'b0, d);
        mStop();
        total++;
        if (d !== modelRegs[3]) begin
            bad++;
            $display("[TB] FAIL post_reset_reg3 got=%h want=%h", d, modelRegs[3]);
        end
    endtask

    initial begin
        sclOeCycles = 0;
        sdaOeSeen   = 1'b0;
        test_reset();
        test_write_basic();
        test_wrap();
        test_nack();
        test_repeated_start_read();
        test_abort_partial();
        test_random();
        test_stretch();
        test_reset_midread();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
